seq_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter: shifts a programmable PAT_W-bit pattern MSB-first onto din-style

---
 rtl/seq_pattern_tx.sv | 149 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial MSB-first pattern transmitter with repeats and idle gaps
// Optional abort/aborted ports when SEQ_TX_ABORT_EN is defined.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
`ifdef SEQ_TX_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             dout,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] TOP_IDX = BIT_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t             state, state_n;
  logic [PAT_W-1:0]   pat_q, pat_n;
  logic [CNT_W-1:0]   reps_q, reps_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [BIT_W-1:0]   bit_idx, bit_idx_n;
  logic               dout_n, bit_valid_n, busy_n, done_n;
`ifdef SEQ_TX_ABORT_EN
  logic               aborted_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      dout      <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_TX_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      pat_q     <= pat_n;
      reps_q    <= reps_n;
      gap_q     <= gap_n;
      gap_cnt   <= gap_cnt_n;
      bit_idx   <= bit_idx_n;
      dout      <= dout_n;
      bit_valid <= bit_valid_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef SEQ_TX_ABORT_EN
      aborted   <= aborted_n;
`endif
    end
  end

  // Outputs are computed one cycle ahead so the registered values line up with the state entered.
  always_comb begin
    state_n     = state;
    pat_n       = pat_q;
    reps_n      = reps_q;
    gap_n       = gap_q;
    gap_cnt_n   = gap_cnt;
    bit_idx_n   = bit_idx;
    dout_n      = 1'b0;
    bit_valid_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
`ifdef SEQ_TX_ABORT_EN
    aborted_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          pat_n       = pattern;
          reps_n      = repeat_cnt;
          gap_n       = gap_len;
          state_n     = SHIFT;
          bit_idx_n   = TOP_IDX;
          dout_n      = pattern[PAT_W-1];
          bit_valid_n = 1'b1;
          busy_n      = 1'b1;
        end
      end
      SHIFT: begin
        busy_n = 1'b1;
        if (bit_idx != '0) begin
          bit_idx_n   = bit_idx - BIT_W'(1);
          dout_n      = pat_q[bit_idx_n];
          bit_valid_n = 1'b1;
        end else if (reps_q != '0) begin
          reps_n = reps_q - CNT_W'(1);
          if (gap_q != '0) begin
            state_n   = GAP;
            gap_cnt_n = gap_q;
          end else begin
            bit_idx_n   = TOP_IDX;
            dout_n      = pat_q[PAT_W-1];
            bit_valid_n = 1'b1;
          end
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == GAP_W'(1)) begin
          state_n     = SHIFT;
          bit_idx_n   = TOP_IDX;
          dout_n      = pat_q[PAT_W-1];
          bit_valid_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
`ifdef SEQ_TX_ABORT_EN
    if (abort && (state == SHIFT || state == GAP)) begin
      state_n     = IDLE;
      dout_n      = 1'b0;
      bit_valid_n = 1'b0;
      busy_n      = 1'b0;
      done_n      = 1'b0;
      aborted_n   = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx
// Abort checks are compiled in when SEQ_TX_ABORT_EN is defined.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       dout, bit_valid, busy, done;
`ifdef SEQ_TX_ABORT_EN
  logic       abort, aborted;
`endif

  int tests = 0;
  int fails = 0;

  // Each entry is {dout, bit_valid, busy, done} for one cycle.
  logic [3:0] exp_q[$];
  logic [3:0] det_win;
  int         det_count;
  bit         det_en;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pattern(pattern),
    .repeat_cnt(repeat_cnt),
    .gap_len(gap_len),
`ifdef SEQ_TX_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .dout(dout),
    .bit_valid(bit_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [3:0] pat, input int reps, input int gap);
    for (int r = 0; r <= reps; r++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      if (r < reps) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
  endtask

  task automatic check_cycle();
    logic [3:0] e;
    e = exp_q.pop_front();
    compare("dout", dout, e[3]);
    compare("bit_valid", bit_valid, e[2]);
    compare("busy", busy, e[1]);
    compare("done", done, e[0]);
    // Non-overlapping Moore 1001 detector fed by the serial line.
    if (det_en) begin
      det_win = {det_win[2:0], dout};
      if (det_win == 4'b1001) begin
        det_count++;
        det_win = 4'b0000;
      end
    end
  endtask

  task automatic run_queue();
    while (exp_q.size() > 0) begin
      check_cycle();
      tick();
    end
  endtask

  initial begin
    det_en = 1'b0; det_win = 4'b0000; det_count = 0;
    reset = 1'b1; start = 1'b1; pattern = 4'b1111; repeat_cnt = 8'd0; gap_len = 4'd0;
`ifdef SEQ_TX_ABORT_EN
    abort = 1'b0;
`endif

    // Reset held with start high: nothing starts.
    repeat (3) begin
      tick();
      push_idle(1);
      check_cycle();
    end
    reset = 1'b0; start = 1'b0;
    push_idle(2);
    run_queue();

    // Single pattern; inputs scrambled after capture.
    pattern = 4'b1001; repeat_cnt = 8'd0; gap_len = 4'd0; start = 1'b1;
    push_frame(4'b1001, 0, 0);
    push_idle(2);
    tick();
    start = 1'b0; pattern = 4'b0110; repeat_cnt = 8'd5; gap_len = 4'd3;
    run_queue();

    // Three patterns with 2-cycle gaps looped into a detector.
    pattern = 4'b1001; repeat_cnt = 8'd2; gap_len = 4'd2; start = 1'b1;
    det_en = 1'b1; det_win = 4'b0000; det_count = 0;
    push_frame(4'b1001, 2, 2);
    push_idle(1);
    tick();
    start = 1'b0;
    run_queue();
    det_en = 1'b0;
    compare("detect_count", det_count, 3);

    // Back-to-back repeat; starts while busy and in DONE ignored, first IDLE start accepted.
    pattern = 4'b1100; repeat_cnt = 8'd1; gap_len = 4'd0; start = 1'b1;
    push_frame(4'b1100, 1, 0);
    push_idle(1);
    push_frame(4'b1100, 1, 0);
    push_idle(1);
    tick();
    for (int c = 1; c <= 20; c++) begin
      check_cycle();
      start = (c == 3 || c == 9 || c == 10);
      tick();
    end
    start = 1'b0;
    push_idle(1);
    run_queue();

    // Reset during the third bit truncates the frame without done.
    pattern = 4'b1001; repeat_cnt = 8'd3; gap_len = 4'd1; start = 1'b1;
    push_frame(4'b1001, 3, 1);
    tick();
    start = 1'b0;
    check_cycle();
    tick();
    check_cycle();
    tick();
    check_cycle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    push_idle(6);
    run_queue();
    pattern = 4'b1010; repeat_cnt = 8'd1; gap_len = 4'd3; start = 1'b1;
    push_frame(4'b1010, 1, 3);
    push_idle(1);
    tick();
    start = 1'b0;
    run_queue();

`ifdef SEQ_TX_ABORT_EN
    // Abort at the second bit; restart accepted in the aborted cycle.
    pattern = 4'b1001; repeat_cnt = 8'd0; gap_len = 4'd0; start = 1'b1;
    push_frame(4'b1001, 0, 0);
    tick();
    start = 1'b0;
    check_cycle();
    tick();
    check_cycle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    push_idle(1);
    check_cycle();
    compare("aborted_pulse", aborted, 1'b1);
    pattern = 4'b0011; start = 1'b1;
    push_frame(4'b0011, 0, 0);
    push_idle(1);
    tick();
    start = 1'b0;
    compare("aborted_clear", aborted, 1'b0);
    run_queue();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
